wb_burst_master: RTL and testbench
==================================

# wb_burst_master

Wishbone B3 burst initiator that turns a single command (address, beat count, direction) into one registered-feedback incrementing burst on a 32-bit Wishbone bus. It is the master-side counterpart of the `wb_ram` responder: it drives a memory such as `wb_ram` directly, for preloading and scrubbing in simulation or as a bulk-transfer front end for the debug subsystem. Read data and write data move as valid/ready streams.

## Interface
- `AW`, 32: Wishbone byte-address width.
- `LEN_W`, 8: width of the beat count; at most 2^LEN_W−1 beats per command.
- `clk` in 1: system clock; all logic is single-clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_we` in 1: 1 = write burst, 0 = read burst.
- `cmd_adr` in AW: start byte address; bits [1:0] are ignored and forced to 0.
- `cmd_len` in LEN_W: number of 32-bit beats.
- `wdata_valid`, `wdata_ready` in/out 1: write-data stream handshake.
- `wdata_dat` in 32, `wdata_sel` in 4: beat data and byte enables.
- `rdata_valid` out 1: one-cycle pulse per read beat; no backpressure.
- `rdata_dat` out 32, `rdata_last` out 1: read beat and final-beat flag.
- `done` out 1: one-cycle pulse when a command completes.
- `done_err` out 1: qualifies `done`; set when the burst was aborted by `err_i` or `rty_i`.
- `wb_adr_o` out AW, `wb_dat_o` out 32, `wb_sel_o` out 4: Wishbone address, write data, byte selects.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone cycle, strobe and write enable.
- `wb_cti_o` out 3, `wb_bte_o` out 2: cycle-type and burst-type identifiers.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i` in 1: slave termination signals.
- `wb_dat_i` in 32: slave read data.

## Operation
- States:
  - IDLE: `cmd_ready`=1; waiting for a command.
  - ACTIVE: the burst is on the bus.
  - DONE: one cycle; `done`=1.
- IDLE→ACTIVE on `cmd_valid && cmd_ready` with `cmd_len`≠0.
- `cmd_len`=0 goes IDLE→DONE: no bus cycle, `done_err`=0.
- Command accept latches `cmd_adr` & ~3, `cmd_len` into a remaining-beat counter, and `cmd_we`.
- ACTIVE behaviour:
  - `wb_cyc_o`=1 for the whole state.
  - `wb_stb_o` = `we` ? `wdata_valid` : 1. Write bursts insert wait states by dropping stb while cyc stays high.
  - `wb_dat_o`/`wb_sel_o` pass through combinationally from the `wdata_*` stream.
  - `wb_sel_o`=4'hF on reads.
  - `wdata_ready` = ACTIVE && `we` && `wb_ack_i`.
  - `wb_bte_o`=2'b00 (linear).
- On each `wb_ack_i` while stb is high:
  - Address advances by 4, wrapping modulo 2^AW.
  - The remaining-beat counter decrements.
  - For reads, `wb_dat_i` is registered to `rdata_dat` and `rdata_valid` pulses; `rdata_last` is set if the counter was 1.
- ACK on the last beat (counter==1) → DONE, `done_err`=0.
- `err_i` or `rty_i` with stb high → DONE, `done_err`=1. That beat is not counted or consumed; no `rdata_valid`, no `wdata_ready`.
- Terminations with stb low are ignored.
- Priority when several terminations are high together: err > rty > ack.
- `rst` mid-burst: cyc/stb drop at the next edge and the FSM returns to IDLE with no `done`.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`=0; `wb_adr_o`=0; `wb_cti_o`=000.
  - `rdata_valid`, `rdata_last`, `done`, `done_err`=0; `rdata_dat`=0.
- Command accepted at edge N → cyc high from cycle N+1.
- Read beat acked in cycle k → `rdata_valid` in cycle k+1.
- Last ack in cycle k → cyc low and `done` high in cycle k+1; `cmd_ready` returns high in cycle k+2.
- No back-to-back bursts: at least 1 idle cycle between cyc deassertion and the next assertion.

## Configuration
- `WB_BURST_MASTER_BURST_EN` defined:
  - `wb_cti_o`=3'b010 (incrementing) while the counter >1.
  - `wb_cti_o`=3'b111 on the final beat.
- Undefined:
  - `wb_cti_o`=3'b000 (classic) throughout.
  - stb is forced low for one cycle after every ack, giving classic single cycles under one held cyc.
  - Counting, addressing and streams are unchanged.

## Structure
- Shared package `wb_pkg`:
  - `CTI_CLASSIC`, `CTI_INCR`, `CTI_EOB`, `BTE_LINEAR` constants.
  - Beat-count and state enum typedefs.
- Single module; no sub-module is warranted. The address/count logic stays inline.

## Test plan
- Read, `cmd_adr`=0x100, len=4, against `wb_ram` preloaded with 0xA0..0xA3 → 4 `rdata_valid` pulses with 0xA0..0xA3.
  - `rdata_last` only on the 4th beat.
  - With the macro: cti 010,010,010,111.
  - `done`=1, `done_err`=0.
- Write len=3 at 0x200 with `wdata_valid` low for 2 cycles before beat 2 → stb drops while cyc stays high; read-back gives all 3 words intact.
- `wb_err_i` on beat 2 of a len=5 read → exactly 1 `rdata_valid`, then `done` with `done_err`=1, and cyc low the next cycle.
- `cmd_len`=0 → `done` in the cycle after accept; cyc never asserts.
- Address wrap: start 0xFFFF_FFFC, len=2 → addresses 0xFFFF_FFFC then 0x0000_0000.
- `rst` asserted on beat 3 of a len=8 burst → cyc=0 on the next cycle, no `done`, `cmd_ready`=1 once reset is released.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone constants and types for the burst master.
package wb_pkg;

  localparam int unsigned WB_AW    = 32;
  localparam int unsigned WB_LEN_W = 8;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_SW    = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  typedef logic [WB_LEN_W-1:0] beat_cnt_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Command, data-stream and Wishbone signal bundle for wb_burst_master.
interface wb_burst_master_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [AW-1:0]    cmd_adr;
  logic [LEN_W-1:0] cmd_len;

  logic             wdata_valid;
  logic             wdata_ready;
  logic [31:0]      wdata_dat;
  logic [3:0]       wdata_sel;

  logic             rdata_valid;
  logic [31:0]      rdata_dat;
  logic             rdata_last;

  logic             done;
  logic             done_err;

  logic [AW-1:0]    wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [3:0]       wb_sel_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic             wb_ack_i;
  logic             wb_err_i;
  logic             wb_rty_i;
  logic [31:0]      wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len,
    input  wdata_valid, wdata_dat, wdata_sel,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    output cmd_ready, wdata_ready, rdata_valid, rdata_dat, rdata_last,
    output done, done_err,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len,
    output wdata_valid, wdata_dat, wdata_sel,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    input  cmd_ready, wdata_ready, rdata_valid, rdata_dat, rdata_last,
    input  done, done_err,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator driven by a single command.
// Define WB_BURST_MASTER_BURST_EN for CTI-tagged bursts; otherwise classic single cycles under one cyc.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned LEN_W = WB_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  wb_burst_master_if.master bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_adr;
  logic [LEN_W-1:0] r_cnt;
  logic             r_we;
  logic             r_gap;
  logic             r_done_err;
  logic             r_rdata_valid;
  logic [31:0]      r_rdata_dat;
  logic             r_rdata_last;

  logic             w_active;
  logic             w_stb;
  logic             w_err;
  logic             w_rty;
  logic             w_ack;
  logic             w_last;
  logic [AW-1:0]    w_adr_aligned;

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_last        = (r_cnt == LEN_W'(1));
  assign w_adr_aligned = bus.cmd_adr & ~AW'(3);

  // Strobe: writes wait on the data stream; classic mode idles one cycle after each ack.
  always_comb begin
    w_stb = 1'b0;
    if (w_active && !r_gap) begin
      w_stb = r_we ? bus.wdata_valid : 1'b1;
    end
  end

  // Terminations only count with stb high; err beats rty beats ack.
  assign w_err = w_stb && bus.wb_err_i;
  assign w_rty = w_stb && bus.wb_rty_i && !bus.wb_err_i;
  assign w_ack = w_stb && bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt = (bus.cmd_len == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_err || w_rty || (w_ack && w_last)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address/count/read-data datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr         <= '0;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_gap         <= 1'b0;
      r_done_err    <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata_dat   <= '0;
      r_rdata_last  <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_gap         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_adr      <= w_adr_aligned;
            r_cnt      <= bus.cmd_len;
            r_we       <= bus.cmd_we;
            r_done_err <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_err || w_rty) begin
            r_done_err <= 1'b1;
          end else if (w_ack) begin
            r_adr <= r_adr + AW'(4);
            r_cnt <= r_cnt - LEN_W'(1);
            if (!r_we) begin
              r_rdata_valid <= 1'b1;
              r_rdata_dat   <= bus.wb_dat_i;
              r_rdata_last  <= w_last;
            end
`ifndef WB_BURST_MASTER_BURST_EN
            r_gap <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.wdata_ready = w_active && r_we && w_ack;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.rdata_dat   = r_rdata_dat;
  assign bus.rdata_last  = r_rdata_last;
  assign bus.done        = (r_state == ST_DONE);
  assign bus.done_err    = (r_state == ST_DONE) && r_done_err;

  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = bus.wdata_dat;
  assign bus.wb_sel_o = r_we ? bus.wdata_sel : 4'hF;
  assign bus.wb_cyc_o = w_active;
  assign bus.wb_stb_o = w_stb;
  assign bus.wb_we_o  = w_active && r_we;
  assign bus.wb_bte_o = BTE_LINEAR;

`ifdef WB_BURST_MASTER_BURST_EN
  assign bus.wb_cti_o = !w_active ? CTI_CLASSIC : (w_last ? CTI_EOB : CTI_INCR);
`else
  assign bus.wb_cti_o = CTI_CLASSIC;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with an inline single-cycle-ack memory slave.
module tb_wb_burst_master;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_burst_master_if #(.AW(32), .LEN_W(8)) bus ();
  wb_burst_master #(.AW(32), .LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [31:0] dat; logic last; } rd_t;
  typedef struct packed { logic [31:0] adr; logic [2:0] cti; } beat_t;

  int    total = 0;
  int    bad   = 0;
  rd_t   exp_rd[$];
  beat_t exp_bt[$];

  logic [31:0] mem [0:1023];
  int          beat_idx = 0;
  int          err_beat = -1;
  int          rty_beat = -1;
  logic        pl_we  = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;
  int          done_cnt = 0;
  int          rd_cnt   = 0;
  logic        last_done_err = 1'b0;

  // Memory slave: acks every strobed beat in the same cycle, err/rty injected by beat index.
  logic w_term_stb, w_beat_ok;
  assign w_term_stb   = bus.wb_cyc_o && bus.wb_stb_o;
  assign bus.wb_ack_i = w_term_stb;
  assign bus.wb_err_i = w_term_stb && (beat_idx == err_beat);
  assign bus.wb_rty_i = w_term_stb && (beat_idx == rty_beat);
  assign bus.wb_dat_i = mem[bus.wb_adr_o[11:2]];
  assign w_beat_ok    = w_term_stb && !bus.wb_err_i && !bus.wb_rty_i;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_dat;
    if (!bus.wb_cyc_o) beat_idx <= 0;
    else if (w_beat_ok) begin
      beat_idx <= beat_idx + 1;
      if (bus.wb_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.wb_sel_o[b]) mem[bus.wb_adr_o[11:2]][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [2:0] cti_exp(input int rem);
`ifdef WB_BURST_MASTER_BURST_EN
    return (rem > 1) ? CTI_INCR : CTI_EOB;
`else
    return (rem > 0) ? CTI_CLASSIC : CTI_CLASSIC;
`endif
  endfunction

  // Mid-cycle monitor: bus beats, write-stream handshake, read stream, done pulses.
  always @(negedge clk) begin
    if (w_beat_ok) begin
      if (exp_bt.size() == 0) chk("beat_queue", 32'(exp_bt.size()), 32'd1);
      else begin
        beat_t b;
        b = exp_bt.pop_front();
        chk("beat_adr", bus.wb_adr_o, b.adr);
        chk("beat_cti", 32'(bus.wb_cti_o), 32'(b.cti));
        chk("beat_bte", 32'(bus.wb_bte_o), 32'(BTE_LINEAR));
        if (!bus.wb_we_o) chk("rd_sel", 32'(bus.wb_sel_o), 32'hF);
      end
    end
    if (bus.wb_cyc_o) chk("wdata_ready", 32'(bus.wdata_ready), 32'(w_beat_ok && bus.wb_we_o));
    if (bus.rdata_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) chk("rd_queue", 32'(exp_rd.size()), 32'd1);
      else begin
        rd_t r;
        r = exp_rd.pop_front();
        chk("rd_dat", bus.rdata_dat, r.dat);
        chk("rd_last", 32'(bus.rdata_last), 32'(r.last));
      end
    end
    if (bus.done) begin
      done_cnt++;
      last_done_err = bus.done_err;
      chk("done_cyc_low", 32'(bus.wb_cyc_o), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
    pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
    step();
    pl_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len);
    logic [31:0] a;
    a = adr & ~32'd3;
    for (int i = 0; i < int'(len); i++)
      exp_bt.push_back('{adr: a + 32'(4 * i), cti: cti_exp(int'(len) - i)});
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_len = len;
    step();
    bus.cmd_valid = 1'b0;
    chk("cyc_after_accept", 32'(bus.wb_cyc_o), 32'(len != 8'd0));
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'(start + 1));
    step();
    chk("cmd_ready_after_done", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, rc, n;
    logic [31:0] wd [3];
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_len = '0;
    bus.wdata_valid = 1'b0; bus.wdata_dat = '0; bus.wdata_sel = 4'hF;
    step(); step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_cti", 32'(bus.wb_cti_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_rlast", 32'(bus.rdata_last), 32'd0);
    chk("rst_rdat", bus.rdata_dat, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_err", 32'(bus.done_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) preload(10'(32'h40 + i), 32'hA0 + 32'(i));

    // Read burst of 4 from 0x100
    dc = done_cnt; rc = rd_cnt;
    for (int i = 0; i < 4; i++) exp_rd.push_back('{dat: 32'hA0 + 32'(i), last: (i == 3)});
    issue(1'b0, 32'h100, 8'd4);
    wait_done(dc);
    chk("t1_done_err", 32'(last_done_err), 32'd0);
    chk("t1_rd_cnt", 32'(rd_cnt - rc), 32'd4);
    chk("t1_beats_left", 32'(exp_bt.size()), 32'd0);

    // Write burst of 3 at 0x200 with a 2-cycle data stall before beat 2
    dc = done_cnt;
    issue(1'b1, 32'h200, 8'd3);
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        bus.wdata_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("t2_stall_cyc", 32'(bus.wb_cyc_o), 32'd1);
          chk("t2_stall_stb", 32'(bus.wb_stb_o), 32'd0);
          step();
        end
      end
      bus.wdata_valid = 1'b1; bus.wdata_dat = wd[b]; bus.wdata_sel = 4'hF;
      n = 0;
      @(negedge clk);
      while (!bus.wdata_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t2_wready", 32'(bus.wdata_ready), 32'd1);
      step();
    end
    bus.wdata_valid = 1'b0;
    wait_done(dc);
    chk("t2_done_err", 32'(last_done_err), 32'd0);
    dc = done_cnt; rc = rd_cnt;
    for (int i = 0; i < 3; i++) exp_rd.push_back('{dat: wd[i], last: (i == 2)});
    issue(1'b0, 32'h200, 8'd3);
    wait_done(dc);
    chk("t2_readback_cnt", 32'(rd_cnt - rc), 32'd3);

    // err_i (with ack also high) on beat 2 of a 5-beat read
    dc = done_cnt; rc = rd_cnt; err_beat = 1;
    exp_rd.push_back('{dat: 32'hA0, last: 1'b0});
    issue(1'b0, 32'h100, 8'd5);
    wait_done(dc);
    chk("t3_done_err", 32'(last_done_err), 32'd1);
    chk("t3_rd_cnt", 32'(rd_cnt - rc), 32'd1);
    chk("t3_beats_left", 32'(exp_bt.size()), 32'd4);
    exp_bt.delete();
    err_beat = -1;

    // rty_i on the first beat of a write: nothing consumed
    dc = done_cnt; rty_beat = 0;
    bus.wdata_valid = 1'b1; bus.wdata_dat = 32'h5555_5555;
    issue(1'b1, 32'h300, 8'd2);
    wait_done(dc);
    chk("t3b_done_err", 32'(last_done_err), 32'd1);
    chk("t3b_beats_left", 32'(exp_bt.size()), 32'd2);
    exp_bt.delete();
    bus.wdata_valid = 1'b0; rty_beat = -1;

    // Zero-length command
    dc = done_cnt;
    issue(1'b0, 32'h400, 8'd0);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_done_err", 32'(bus.done_err), 32'd0);
    step();
    chk("t4_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Address wrap from the top of the space, unaligned start
    preload(10'h3FF, 32'hC0FF_EE00);
    preload(10'h000, 32'hC0FF_EE01);
    dc = done_cnt; rc = rd_cnt;
    exp_rd.push_back('{dat: 32'hC0FF_EE00, last: 1'b0});
    exp_rd.push_back('{dat: 32'hC0FF_EE01, last: 1'b1});
    issue(1'b0, 32'hFFFF_FFFE, 8'd2);
    wait_done(dc);
    chk("t5_rd_cnt", 32'(rd_cnt - rc), 32'd2);
    chk("t5_beats_left", 32'(exp_bt.size()), 32'd0);

    // Reset during beat 3 of an 8-beat read
    dc = done_cnt; rc = rd_cnt;
    exp_rd.push_back('{dat: 32'hA0, last: 1'b0});
    exp_rd.push_back('{dat: 32'hA1, last: 1'b0});
    issue(1'b0, 32'h100, 8'd8);
    n = 0;
    while (!(beat_idx == 2 && bus.wb_stb_o) && n < 50) begin
      step();
      n++;
    end
    chk("t6_reached_beat3", 32'(beat_idx), 32'd2);
    rst = 1'b1;
    step();
    chk("t6_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("t6_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t6_no_done", 32'(done_cnt), 32'(dc));
    chk("t6_rd_cnt", 32'(rd_cnt - rc), 32'd2);
    exp_bt.delete();
    step();
    chk("end_rd_queue", 32'(exp_rd.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
